// File: rtl/tft_capture_rx_if.sv
// Parallel TFT video bus (DCLK/HS/VS/DE + RGB666) together with the write-FIFO
// side that carries captured pixels towards the SDRAM controller.
interface tft_capture_rx_if #(
  parameter int PAGE_W = 3
);
  logic               DCLK_in;
  logic               HS_in;
  logic               VS_in;
  logic               DE_in;
  logic [5:0]         R_in;
  logic [5:0]         G_in;
  logic [5:0]         B_in;
  logic               FIFO_full;
  logic               FIFO_WR_req;
  logic [PAGE_W+34:0] FIFO_in;

  modport master (
    output DCLK_in, HS_in, VS_in, DE_in, R_in, G_in, B_in, FIFO_full,
    input  FIFO_WR_req, FIFO_in
  );

  modport slave (
    input  DCLK_in, HS_in, VS_in, DE_in, R_in, G_in, B_in, FIFO_full,
    output FIFO_WR_req, FIFO_in
  );
endinterface

// File: rtl/tft_capture_rx.sv
// Oversampling TFT receiver: captures active RGB666 pixels, converts them to
// RGB565 and pushes {page,row,col,pixel} into the SDRAM write FIFO.
module tft_capture_rx #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int PAGE_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  tft_capture_rx_if.slave   bus,
  input  logic              capture_en,
  input  logic [PAGE_W-1:0] page_set,
  input  logic              err_clr,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              ovf_err,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [9:0] COL_END  = 10'(H_ACTIVE);
  localparam logic [8:0] ROW_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DE, LINE, DONE} state_t;

  state_t            state;
  logic [21:0]       sync1, sync2;
  logic [2:0]        edge_prev;
  logic              dclk_s, hs_s, vs_s, de_s;
  logic [5:0]        r_s, g_s, b_s;
  logic [2:0]        sync_unused;
  logic              pix_evt, pix_de, de_rise_evt, de_fall_evt, vs_fall_evt;
  logic [15:0]       pix_data;
  logic [8:0]        row;
  logic [9:0]        col;
  logic [PAGE_W-1:0] page;
  logic              take, col_full, wr, ovf_set, line_set, frame_set;

  assign {dclk_s, hs_s, vs_s, de_s, r_s, g_s, b_s} = sync2;
  // HS is carried through the synchroniser but the capture keys off DE only.
  assign sync_unused = {hs_s, r_s[0], b_s[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      edge_prev <= '0;
    end else begin
      sync1     <= {bus.DCLK_in, bus.HS_in, bus.VS_in, bus.DE_in,
                    bus.R_in, bus.G_in, bus.B_in};
      sync2     <= sync1;
      edge_prev <= {dclk_s, vs_s, de_s};
    end
  end

  // Registered edge events; the pixel is taken on the DCLK falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_evt     <= 1'b0;
      pix_de      <= 1'b0;
      de_rise_evt <= 1'b0;
      de_fall_evt <= 1'b0;
      vs_fall_evt <= 1'b0;
      pix_data    <= '0;
    end else begin
      pix_evt     <= edge_prev[2] & ~dclk_s;
      vs_fall_evt <= edge_prev[1] & ~vs_s;
      de_rise_evt <= ~edge_prev[0] & de_s;
      de_fall_evt <= edge_prev[0] & ~de_s;
      pix_de      <= de_s;
      pix_data    <= {r_s[5:1], g_s, b_s[5:1]};
    end
  end

  assign take      = (state == LINE) && pix_evt && pix_de;
  assign col_full  = (col == COL_END);
  assign wr        = take && !col_full && !bus.FIFO_full;
  assign ovf_set   = take && !col_full && bus.FIFO_full;
  assign line_set  = (take && col_full)
                   || ((state == LINE) && de_fall_evt && !col_full)
                   || ((state == DONE) && de_rise_evt);
  assign frame_set = vs_fall_evt && ((state == WAIT_DE) || (state == LINE));

  // Frame FSM; a VS fall restarts from any state, so it is handled first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      page        <= '0;
      bus.FIFO_WR_req <= 1'b0;
      bus.FIFO_in <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      ovf_err     <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      bus.FIFO_WR_req <= wr;
      frame_done  <= 1'b0;
      if (wr) begin
        bus.FIFO_in <= {page, row, col, pix_data};
      end
      ovf_err   <= (ovf_err & ~err_clr) | ovf_set;
      line_err  <= (line_err & ~err_clr) | line_set;
      frame_err <= (frame_err & ~err_clr) | frame_set;

      if (vs_fall_evt) begin
        if (capture_en) begin
          state <= WAIT_DE;
          row   <= '0;
          col   <= '0;
          page  <= page_set;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          WAIT_DE: begin
            if (de_rise_evt) begin
              state <= LINE;
            end
          end
          LINE: begin
            if (take && !col_full) begin
              col <= col + 10'd1;
            end
            if (de_fall_evt) begin
              col <= '0;
              if (row == ROW_LAST) begin
                state      <= DONE;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
              end else begin
                row   <= row + 9'd1;
                state <= WAIT_DE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
